hub75_rx: RTL and testbench

- Receiving end of the HUB75 LED-matrix interface.
- Oversamples HUB75 pins on the system clock and reconstructs the row shift register and latch behaviour of a 64-column, 1/32-scan panel.
- Drains each latched row pair as a stream of pixel writes.
- Used as a loopback checker and frame-capture path for the panel driver, and as a bench-side panel model.

---
 rtl/hub75_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_hub75_rx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel receiver; rebuilds the 64-col row shift/latch of a 1/32-scan panel and drains each latched row pair as pixel beats.
// Latency: pix_valid rises on the 4th clk_in edge after the edge that first samples hub_lat high (SYNC_STAGES=2); one beat per cycle when pix_ready is high.
// Backpressure: pix_ready low holds the presented beat; shifting continues meanwhile, and a latch that arrives mid-drain is dropped and flagged as overrun.
module hub75_rx #(
   parameter int COLS        = 64,
   parameter int ROW_BITS    = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_in,
   input  logic                reset_n,
   input  logic                hub_clk,
   input  logic                hub_lat,
   input  logic                hub_oe,
   input  logic [ROW_BITS-1:0] hub_addr,
   input  logic [2:0]          hub_rgb1,
   input  logic [2:0]          hub_rgb2,
   output logic                pix_valid,
   input  logic                pix_ready,
   output logic [ROW_BITS:0]   pix_row,
   output logic [5:0]          pix_col,
   output logic [2:0]          pix_rgb,
   output logic                row_done,
   output logic                len_err,
   output logic                overrun,
   output logic                oe_active,
   input  logic                clr_err
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   // Packed pin vector: {oe, lat, clk, addr, rgb1, rgb2}
   localparam int PW    = 3 + ROW_BITS + 6;
   localparam int P_OE  = PW - 1;
   localparam int P_LAT = PW - 2;
   localparam int P_CLK = PW - 3;
   localparam logic [PW-1:0] PIN_RST = {1'b1, {(PW-1){1'b0}}};
   localparam logic [6:0]    CNT_COLS = 7'(COLS);
   localparam logic [6:0]    CNT_MAX  = 7'd127;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_TOP  = 2'd1;
   localparam logic [1:0] ST_BOT  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [PW-1:0] pins;
   logic [PW-1:0] pins_s;
   logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;

   // Edge-detect stage: events and the data that belongs to them travel together.
   logic                clk_prev_q, clk_prev_d;
   logic                lat_prev_q, lat_prev_d;
   logic                shift_ev_q, shift_ev_d;
   logic                lat_ev_q, lat_ev_d;
   logic [ROW_BITS-1:0] ev_addr_q, ev_addr_d;
   logic [2:0]          ev_top_q, ev_top_d;
   logic [2:0]          ev_bot_q, ev_bot_d;

   // Capture: shift registers, snapshots, shift counter, sticky flags.
   logic [COLS-1:0][2:0] sr_top_q, sr_top_d;
   logic [COLS-1:0][2:0] sr_bot_q, sr_bot_d;
   logic [COLS-1:0][2:0] snap_top_q, snap_top_d;
   logic [COLS-1:0][2:0] snap_bot_q, snap_bot_d;
   logic [6:0]           cnt_q, cnt_d;
   logic [6:0]           cnt_inc;
   logic [ROW_BITS-1:0]  row_q, row_d;
   logic                 start_q, start_d;
   logic                 len_err_q, len_err_d;
   logic                 overrun_q, overrun_d;
   logic                 idle;
   logic                 take;

   // Drain: FSM plus registered beat outputs.
   logic [1:0]          state_q, state_d;
   logic                valid_q, valid_d;
   logic [ROW_BITS:0]   prow_q, prow_d;
   logic [5:0]          pcol_q, pcol_d;
   logic [2:0]          prgb_q, prgb_d;
   logic [5:0]          col_nxt;
   logic                last_col;

   assign pins   = {hub_oe, hub_lat, hub_clk, hub_addr, hub_rgb1, hub_rgb2};
   assign pins_s = sync_q[SYNC_STAGES-1];

   // Synchroniser shift and edge detection on the synced clk/lat pins.
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], pins};
      clk_prev_d = pins_s[P_CLK];
      lat_prev_d = pins_s[P_LAT];
      shift_ev_d = pins_s[P_CLK] & ~clk_prev_q;
      lat_ev_d   = pins_s[P_LAT] & ~lat_prev_q;
      ev_addr_d  = pins_s[6 +: ROW_BITS];
      ev_top_d   = pins_s[3 +: 3];
      ev_bot_d   = pins_s[0 +: 3];
   end

   // Shift first, then latch: a shift and latch in the same cycle both see the new bit.
   always_comb begin
      sr_top_d = sr_top_q;
      sr_bot_d = sr_bot_q;
      if (shift_ev_q) begin
         sr_top_d = {sr_top_q[COLS-2:0], ev_top_q};
         sr_bot_d = {sr_bot_q[COLS-2:0], ev_bot_q};
      end

      cnt_inc = cnt_q;
      if (shift_ev_q && (cnt_q != CNT_MAX)) begin
         cnt_inc = cnt_q + 7'd1;
      end
      cnt_d = lat_ev_q ? 7'd0 : cnt_inc;

      // A latch still waiting to start its drain counts as busy.
      idle = (state_q == ST_IDLE) && !start_q;
      take = lat_ev_q && idle;

      start_d    = take;
      snap_top_d = take ? sr_top_d  : snap_top_q;
      snap_bot_d = take ? sr_bot_d  : snap_bot_q;
      row_d      = take ? ev_addr_q : row_q;

      // Set beats clear when both happen in one cycle.
      len_err_d = (len_err_q && !clr_err) || (lat_ev_q && (cnt_inc != CNT_COLS));
      overrun_d = (overrun_q && !clr_err) || (lat_ev_q && !idle);
   end

   // Drain FSM: top half then bottom half, column 0 is the oldest of the last COLS shifts.
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      prow_d   = prow_q;
      pcol_d   = pcol_q;
      prgb_d   = prgb_q;
      col_nxt  = pcol_q + 6'd1;
      last_col = (pcol_q[CW-1:0] == {CW{1'b1}});

      case (state_q)
         ST_IDLE: begin
            if (start_q) begin
               state_d = ST_TOP;
               valid_d = 1'b1;
               prow_d  = {1'b0, row_q};
               pcol_d  = 6'd0;
               prgb_d  = snap_top_q[COLS-1];
            end
         end
         ST_TOP: begin
            if (pix_ready) begin
               if (last_col) begin
                  state_d = ST_BOT;
                  prow_d  = {1'b1, row_q};
                  pcol_d  = 6'd0;
                  prgb_d  = snap_bot_q[COLS-1];
               end else begin
                  pcol_d = col_nxt;
                  prgb_d = snap_top_q[~col_nxt[CW-1:0]];
               end
            end
         end
         ST_BOT: begin
            if (pix_ready) begin
               if (last_col) begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
               end else begin
                  pcol_d = col_nxt;
                  prgb_d = snap_bot_q[~col_nxt[CW-1:0]];
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset; a reset mid-drain abandons the row.
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         sync_q     <= {SYNC_STAGES{PIN_RST}};
         clk_prev_q <= 1'b0;
         lat_prev_q <= 1'b0;
         shift_ev_q <= 1'b0;
         lat_ev_q   <= 1'b0;
         ev_addr_q  <= '0;
         ev_top_q   <= '0;
         ev_bot_q   <= '0;
         sr_top_q   <= '0;
         sr_bot_q   <= '0;
         snap_top_q <= '0;
         snap_bot_q <= '0;
         cnt_q      <= '0;
         row_q      <= '0;
         start_q    <= 1'b0;
         len_err_q  <= 1'b0;
         overrun_q  <= 1'b0;
         state_q    <= ST_IDLE;
         valid_q    <= 1'b0;
         prow_q     <= '0;
         pcol_q     <= '0;
         prgb_q     <= '0;
      end else begin
         sync_q     <= sync_d;
         clk_prev_q <= clk_prev_d;
         lat_prev_q <= lat_prev_d;
         shift_ev_q <= shift_ev_d;
         lat_ev_q   <= lat_ev_d;
         ev_addr_q  <= ev_addr_d;
         ev_top_q   <= ev_top_d;
         ev_bot_q   <= ev_bot_d;
         sr_top_q   <= sr_top_d;
         sr_bot_q   <= sr_bot_d;
         snap_top_q <= snap_top_d;
         snap_bot_q <= snap_bot_d;
         cnt_q      <= cnt_d;
         row_q      <= row_d;
         start_q    <= start_d;
         len_err_q  <= len_err_d;
         overrun_q  <= overrun_d;
         state_q    <= state_d;
         valid_q    <= valid_d;
         prow_q     <= prow_d;
         pcol_q     <= pcol_d;
         prgb_q     <= prgb_d;
      end
   end

   assign pix_valid = valid_q;
   assign pix_row   = prow_q;
   assign pix_col   = pcol_q;
   assign pix_rgb   = prgb_q;
   assign row_done  = (state_q == ST_DONE);
   assign len_err   = len_err_q;
   assign overrun   = overrun_q;
   assign oe_active = ~pins_s[P_OE];

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: drives HUB75 pin waveforms into hub75_rx and checks every drained beat against a pixel-history model.
// The model keeps every shifted pixel in a queue; a latch yields the last COLS pixels, top half then bottom half.
// Table rows cover pattern/random data, ready styles and latch shapes; hand sequences cover latency, overrun, same-edge latch and reset.
module tb_hub75_rx;
   localparam int COLS = 64;

   logic       clk_in = 1'b0;
   logic       reset_n, hub_clk, hub_lat, hub_oe;
   logic [4:0] hub_addr;
   logic [2:0] hub_rgb1, hub_rgb2;
   logic       pix_valid, pix_ready;
   logic [5:0] pix_row, pix_col;
   logic [2:0] pix_rgb;
   logic       row_done, len_err, overrun, oe_active, clr_err;

   hub75_rx dut (
      .clk_in(clk_in), .reset_n(reset_n),
      .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
      .hub_addr(hub_addr), .hub_rgb1(hub_rgb1), .hub_rgb2(hub_rgb2),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_row(pix_row), .pix_col(pix_col), .pix_rgb(pix_rgb),
      .row_done(row_done), .len_err(len_err), .overrun(overrun),
      .oe_active(oe_active), .clr_err(clr_err)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int n_shift;
      int addr;
      int pat;      // 0: top = index mod 8, bottom = ~top; 1: random
      int rmode;    // 0: always ready, 1: toggle, 2: random, 3: never
      int lat_len;  // cycles hub_lat is held high
      int exp_len;  // expected len_err after the latch
   } vec_t;

   vec_t vecs[6];

   int n_pass  = 0;
   int n_total = 0;
   int ready_mode = 3;
   int done_cnt = 0;
   int vcyc = 0;
   int le_hi = 0;

   logic [5:0]  hist[$];   // {top, bottom} per shift, oldest first
   logic [14:0] exp_q[$];  // {row, col, rgb}
   logic [14:0] got_q[$];
   logic        stall_prev = 1'b0;
   logic [15:0] stall_vec = '0;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   // Downstream ready generator.
   always @(posedge clk_in) begin
      #1;
      case (ready_mode)
         0:       pix_ready = 1'b1;
         1:       pix_ready = ~pix_ready;
         2:       pix_ready = 1'($urandom_range(0, 1));
         default: pix_ready = 1'b0;
      endcase
   end

   // Beat collector and stall-stability monitor, sampled mid-cycle.
   always @(negedge clk_in) begin
      if (stall_prev) check("stall_hold", {pix_valid, pix_row, pix_col, pix_rgb}, stall_vec);
      stall_prev = reset_n && pix_valid && !pix_ready;
      stall_vec  = {pix_valid, pix_row, pix_col, pix_rgb};
      if (reset_n && pix_valid && pix_ready) got_q.push_back({pix_row, pix_col, pix_rgb});
      if (pix_valid) vcyc++;
      if (row_done) done_cnt++;
      if (len_err) le_hi++;
   end

   // Model: a latch exposes the last COLS shifted pixels (zeros if fewer since reset).
   function automatic void build_exp(input logic [4:0] addr);
      for (int h = 0; h < 2; h++) begin
         for (int c = 0; c < COLS; c++) begin
            int idx;
            logic [5:0] px;
            idx = hist.size() - COLS + c;
            px  = (idx >= 0) ? hist[idx] : 6'd0;
            exp_q.push_back({1'(h), addr, 6'(c), (h == 0) ? px[5:3] : px[2:0]});
         end
      end
   endfunction

   task automatic do_shift(input logic [2:0] t, input logic [2:0] b, input bit with_lat);
      hub_rgb1 = t;
      hub_rgb2 = b;
      tick(3);
      hub_clk = 1'b1;
      if (with_lat) hub_lat = 1'b1;
      hist.push_back({t, b});
      tick(3);
      hub_clk = 1'b0;
      hub_lat = 1'b0;
   endtask

   task automatic do_latch(input logic [4:0] addr, input int len);
      hub_addr = addr;
      tick(3);
      hub_lat = 1'b1;
      tick(len);
      hub_lat = 1'b0;
      tick(3);
   endtask

   task automatic rand_shifts(input int n);
      for (int i = 0; i < n; i++) do_shift(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
   endtask

   task automatic clear_row();
      got_q.delete();
      exp_q.delete();
      done_cnt = 0;
      vcyc = 0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (done_cnt == 0 && k < 4000) begin
         tick(1);
         k++;
      end
      check({name, "_done_seen"}, (done_cnt != 0), 1);
      tick(20);
   endtask

   task automatic compare_beats(input string name);
      check({name, "_beat_cnt"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) check({name, "_beat"}, got_q[i], exp_q[i]);
      end
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
   endtask

   task automatic run_row(input vec_t v, input string name);
      logic [2:0] tops[128];
      logic [2:0] t, b;
      ready_mode = v.rmode;
      clear_row();
      hub_addr = 5'(v.addr);
      for (int i = 0; i < v.n_shift; i++) begin
         if (v.pat == 0) begin
            t = 3'(i % 8);
            b = ~t;
         end else begin
            t = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
         end
         tops[i] = t;
         do_shift(t, b, 1'b0);
      end
      do_latch(5'(v.addr), v.lat_len);
      build_exp(5'(v.addr));
      wait_done(name);
      compare_beats(name);
      check({name, "_row_done_cnt"}, done_cnt, 1);
      check({name, "_len_err"}, len_err, v.exp_len);
      check({name, "_overrun"}, overrun, 0);
      if (v.n_shift >= COLS && got_q.size() > 0)
         check({name, "_col0"}, got_q[0][2:0], tops[v.n_shift - COLS]);
      if (v.rmode == 0) check({name, "_drain_cycles"}, vcyc, 2 * COLS);
      if (v.rmode == 1) check({name, "_drain_cycles_toggle"}, (vcyc >= 4 * COLS - 1 && vcyc <= 4 * COLS), 1);
      pulse_clr();
      check({name, "_len_err_clr"}, len_err, 0);
   endtask

   initial begin
      int lat_seen;
      int k;
      bit found;
      logic [2:0] last_t;

      vecs[0] = '{64, 5,  0, 0, 3,   0};
      vecs[1] = '{64, 5,  0, 1, 3,   0};
      vecs[2] = '{63, 12, 1, 0, 3,   1};
      vecs[3] = '{70, 31, 1, 2, 3,   1};
      vecs[4] = '{64, 0,  1, 2, 300, 0};
      vecs[5] = '{64, 17, 1, 1, 3,   0};

      reset_n = 1'b0; hub_clk = 1'b0; hub_lat = 1'b0; hub_oe = 1'b1;
      hub_addr = '0; hub_rgb1 = '0; hub_rgb2 = '0; pix_ready = 1'b0; clr_err = 1'b0;
      tick(4);
      check("rst_valid", pix_valid, 0);
      check("rst_row_done", row_done, 0);
      check("rst_flags", {len_err, overrun}, 0);
      check("rst_oe_active", oe_active, 0);
      check("rst_beat", {pix_row, pix_col, pix_rgb}, 0);
      reset_n = 1'b1;
      tick(4);
      check("post_rst_valid", pix_valid, 0);

      // hub_oe only reaches oe_active, after the synchroniser depth.
      hub_oe = 1'b0;
      tick(1);
      check("oe_lat1", oe_active, 0);
      tick(1);
      check("oe_lat2", oe_active, 1);
      hub_oe = 1'b1;
      tick(2);
      check("oe_off", oe_active, 0);

      // Latch-to-valid latency on a full row.
      ready_mode = 0;
      clear_row();
      rand_shifts(64);
      hub_addr = 5'd9;
      tick(3);
      hub_lat = 1'b1;
      lat_seen = 0;
      for (int i = 1; i <= 8; i++) begin
         tick(1);
         if (pix_valid && lat_seen == 0) lat_seen = i;
      end
      hub_lat = 1'b0;
      build_exp(5'd9);
      check("lat_to_valid_edges", lat_seen, 5);
      wait_done("latency");
      compare_beats("latency");

      foreach (vecs[i]) run_row(vecs[i], $sformatf("vec%0d", i));

      // Set and clear in the same cycle: len_err must be visible for exactly one cycle.
      ready_mode = 0;
      clear_row();
      clr_err = 1'b1;
      le_hi = 0;
      rand_shifts(10);
      do_latch(5'd2, 3);
      build_exp(5'd2);
      tick(10);
      clr_err = 1'b0;
      check("clr_set_wins", le_hi, 1);
      wait_done("clrset");
      compare_beats("clrset");
      check("clrset_len_err", len_err, 0);

      // Overrun: second latch during a stalled drain is dropped; shifting carries on.
      ready_mode = 3;
      clear_row();
      rand_shifts(64);
      do_latch(5'd9, 3);
      build_exp(5'd9);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick(1);
         found = pix_valid;
      end
      check("ovr_drain_started", found, 1);
      tick(10);
      rand_shifts(64);
      do_latch(5'd3, 3);
      tick(6);
      check("ovr_flag", overrun, 1);
      check("ovr_len_err", len_err, 0);
      check("ovr_held_beat", {pix_valid, pix_row, pix_col}, {1'b1, 6'd9, 6'd0});
      ready_mode = 0;
      wait_done("ovr");
      tick(300);
      compare_beats("ovr");
      check("ovr_single_drain", done_cnt, 1);
      check("ovr_sticky", overrun, 1);
      pulse_clr();
      check("ovr_clr", overrun, 0);

      // Final clock edge and latch edge together: the 64th pixel lands at col 63.
      ready_mode = 2;
      clear_row();
      hub_addr = 5'd20;
      rand_shifts(63);
      last_t = 3'($urandom_range(0, 7));
      do_shift(last_t, 3'($urandom_range(0, 7)), 1'b1);
      tick(3);
      build_exp(5'd20);
      wait_done("same_edge");
      compare_beats("same_edge");
      check("same_edge_len_err", len_err, 0);
      if (got_q.size() > 63) check("same_edge_col63", got_q[63][2:0], last_t);

      // Reset during the bottom half abandons the row and clears the flags.
      ready_mode = 2;
      clear_row();
      rand_shifts(63);
      do_latch(5'd7, 3);
      found = 0;
      k = 0;
      while (!found && k < 2000) begin
         tick(1);
         found = pix_valid && pix_row[5];
         k++;
      end
      check("rst_reach_bot", found, 1);
      check("rst_pre_len_err", len_err, 1);
      reset_n = 1'b0;
      tick(1);
      check("midrst_valid", pix_valid, 0);
      check("midrst_row_done", row_done, 0);
      check("midrst_flags", {len_err, overrun}, 0);
      check("midrst_beat", {pix_row, pix_col, pix_rgb}, 0);
      reset_n = 1'b1;
      hist.delete();
      clear_row();
      tick(30);
      check("midrst_no_beats", got_q.size(), 0);
      check("midrst_no_done", done_cnt, 0);
      run_row('{64, 22, 1, 0, 3, 0}, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
